sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/ws2_mem_pkg.sv | 22 ++
 rtl/rr_prio_select.sv | 30 +++
 rtl/sdram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2_mem_pkg.sv
// Shared types for the SDRAM arbiter: FSM state encoding, port index and the
// default starvation limit.
package ws2_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_e;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    localparam int STARVE_MAX_DEFAULT = 32;

    function automatic port_idx_t other_port(input port_idx_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational winner selection between the two requesters:
// starvation limit first, then the urgent VGA flag, then round-robin.
module rr_prio_select
    import ws2_mem_pkg::*;
(
    input  logic      req0,
    input  logic      req1,
    input  logic      urgent,
    input  logic      starve_hit,
    input  port_idx_t last_grant,
    output logic      grant_valid,
    output port_idx_t grant_port
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = PORT0;
        // The urgent flag never beats a saturated starve counter.
        if (starve_hit && req1) begin
            grant_port = PORT1;
        end else if (urgent && req0) begin
            grant_port = PORT0;
        end else if (req0 && req1) begin
            grant_port = other_port(last_grant);
        end else if (req1) begin
            grant_port = PORT1;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single SDRAM controller slave,
// one transaction (and at most one read) in flight at a time.
//
//   state  | meaning
//   IDLE   | arbitrate pending requests, register winner's command into s_*
//   ISSUE  | hold s_* until the slave drops s_waitrequest
//   RDWAIT | wait for s_readdatavalid, forward data to the granted port
module sdram_arbiter
    import ws2_mem_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_urgent,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic                s_readdatavalid,
    input  logic [DATA_W-1:0]   s_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e          state_q, state_d;
    port_idx_t           last_q, last_d;
    logic [CNT_W-1:0]    starve_q, starve_d;

    logic                s_read_q, s_read_d;
    logic                s_write_q, s_write_d;
    logic [ADDR_W-1:0]   s_address_q, s_address_d;
    logic [DATA_W-1:0]   s_writedata_q, s_writedata_d;
    logic [BE_W-1:0]     s_byteenable_q, s_byteenable_d;

    logic                m0_rdv_q, m0_rdv_d;
    logic                m1_rdv_q, m1_rdv_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                req0, req1;
    logic                starve_hit;
    logic                win_valid;
    port_idx_t           win_port;
    logic                win_rd, win_wr;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [BE_W-1:0]     win_be;
    logic                accept;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    assign starve_hit = (starve_q == STARVE_LIM);

    rr_prio_select u_sel (
        .req0        (req0),
        .req1        (req1),
        .urgent      (m0_urgent),
        .starve_hit  (starve_hit),
        .last_grant  (last_q),
        .grant_valid (win_valid),
        .grant_port  (win_port)
    );

    assign win_rd    = (win_port == PORT1) ? m1_read       : m0_read;
    assign win_wr    = (win_port == PORT1) ? m1_write      : m0_write;
    assign win_addr  = (win_port == PORT1) ? m1_address    : m0_address;
    assign win_wdata = (win_port == PORT1) ? m1_writedata  : m0_writedata;
    assign win_be    = (win_port == PORT1) ? m1_byteenable : m0_byteenable;

    // Waitrequest tracks the slave combinationally so the master sees the
    // acceptance in the very cycle the slave takes the command.
    assign accept         = (state_q == ISSUE) && !s_waitrequest;
    assign m0_waitrequest = !(accept && (last_q == PORT0));
    assign m1_waitrequest = !(accept && (last_q == PORT1));

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        starve_d       = starve_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        s_address_d    = s_address_q;
        s_writedata_d  = s_writedata_q;
        s_byteenable_d = s_byteenable_q;
        m0_rdv_d       = 1'b0;
        m1_rdv_d       = 1'b0;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d        = ISSUE;
                    last_d         = win_port;
                    s_address_d    = win_addr;
                    s_read_d       = win_rd;
                    s_write_d      = win_wr & ~win_rd;
                    s_writedata_d  = win_wdata;
                    s_byteenable_d = win_be;
                    if (win_port == PORT1) begin
                        starve_d = '0;
                    end else if (req1 && !starve_hit) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (!s_waitrequest) begin
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = s_read_q ? RDWAIT : IDLE;
                end
            end
            RDWAIT: begin
                if (s_readdatavalid) begin
                    state_d = IDLE;
                    if (last_q == PORT0) begin
                        m0_rdata_d = s_readdata;
                        m0_rdv_d   = 1'b1;
                    end else begin
                        m1_rdata_d = s_readdata;
                        m1_rdv_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            last_q         <= PORT1;
            starve_q       <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            s_address_q    <= '0;
            s_writedata_q  <= '0;
            s_byteenable_q <= '0;
            m0_rdv_q       <= 1'b0;
            m1_rdv_q       <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            starve_q       <= starve_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            s_address_q    <= s_address_d;
            s_writedata_q  <= s_writedata_d;
            s_byteenable_q <= s_byteenable_d;
            m0_rdv_q       <= m0_rdv_d;
            m1_rdv_q       <= m1_rdv_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
        end
    end

    assign s_read           = s_read_q;
    assign s_write          = s_write_q;
    assign s_address        = s_address_q;
    assign s_writedata      = s_writedata_q;
    assign s_byteenable     = s_byteenable_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;
    assign m0_readdata      = m0_rdata_q;
    assign m1_readdata      = m1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: SDRAM slave model, two master
// drivers and a transaction-level arbitration/data reference model.
module tb_sdram_arbiter;

    localparam int AW   = 25;
    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int SMAX = 32;
    localparam int WAIT_BOUND = 3000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
    logic          m0_urgent = 1'b0;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] s_address;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic          s_waitrequest;
    logic          s_readdatavalid;
    logic [DW-1:0] s_readdata;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_urgent(m0_urgent), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid),
        .s_readdata(s_readdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- memories ----------------
    logic [DW-1:0] sd_mem  [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] sd_get(input logic [AW-1:0] a);
        return sd_mem.exists(a) ? sd_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    // ---------------- SDRAM slave model ----------------
    int  stall_cfg = -1;
    int  lat_cfg   = -1;
    bit  stray_req = 0;

    initial begin
        logic          smp_rd, smp_wr, smp_w;
        logic [AW-1:0] smp_a;
        logic [DW-1:0] smp_d, rd_data;
        logic [BW-1:0] smp_be;
        int  rd_cnt, stall;
        bit  in_cmd;
        rd_cnt = 0; stall = 0; in_cmd = 0; rd_data = '0;
        s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_readdata = '0;
        forever begin
            @(negedge clk);
            smp_rd = s_read; smp_wr = s_write; smp_a = s_address;
            smp_d = s_writedata; smp_be = s_byteenable; smp_w = s_waitrequest;
            @(posedge clk); #1;
            s_readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin s_readdatavalid = 1'b1; s_readdata = rd_data; end
            end
            if (stray_req) begin
                stray_req = 0; s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
            end
            if ((smp_rd || smp_wr) && !smp_w) begin
                in_cmd = 0;
                if (smp_rd) begin
                    rd_data = sd_get(smp_a);
                    rd_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                end else begin
                    sd_mem[smp_a] = merge(sd_get(smp_a), smp_d, smp_be);
                end
            end
            if (!reset_n) in_cmd = 0;
            if ((s_read || s_write) && !in_cmd) begin
                in_cmd = 1;
                stall  = (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 3));
            end else if (in_cmd && stall > 0) begin
                stall--;
            end
            s_waitrequest = in_cmd ? (stall > 0) : 1'b1;
        end
    end

    // ---------------- reference model / monitor ----------------
    logic [DW-1:0] exp_q0[$], exp_q1[$];
    bit            act_q[$];
    int            mdl_starve = 0;
    bit            mdl_last = 1;
    bit            own = 1;
    bit            prev_cmd = 0;
    logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
    int            rdv_cnt0 = 0, rdv_cnt1 = 0;
    logic          p_rd0, p_wr0, p_rd1, p_wr1, p_urg;
    logic [AW-1:0] p_a0, p_a1;
    logic [DW-1:0] p_d0, p_d1;
    logic [BW-1:0] p_be0, p_be1;

    always @(negedge clk) begin
        bit p0, p1, e, acc, e_rd, e_wr;
        if (!reset_n) begin
            mdl_starve = 0; mdl_last = 1; own = 1;
            exp_q0.delete(); exp_q1.delete();
            last_rd0 = '0; last_rd1 = '0;
        end else begin
            if (m0_readdatavalid) begin
                check("rd0_outstanding", exp_q0.size() > 0, 1);
                if (exp_q0.size() > 0) check("rd0_data", m0_readdata, exp_q0.pop_front());
                last_rd0 = m0_readdata; rdv_cnt0++;
            end else check("rd0_hold", m0_readdata, last_rd0);
            if (m1_readdatavalid) begin
                check("rd1_outstanding", exp_q1.size() > 0, 1);
                if (exp_q1.size() > 0) check("rd1_data", m1_readdata, exp_q1.pop_front());
                last_rd1 = m1_readdata; rdv_cnt1++;
            end else check("rd1_hold", m1_readdata, last_rd1);

            if ((s_read || s_write) && !prev_cmd) begin
                p0 = p_rd0 | p_wr0;
                p1 = p_rd1 | p_wr1;
                if (mdl_starve == SMAX && p1)  e = 1;
                else if (p_urg && p0)          e = 0;
                else if (p0 && p1)             e = !mdl_last;
                else                           e = p1;
                e_rd = e ? p_rd1 : p_rd0;
                e_wr = e ? (p_wr1 & !p_rd1) : (p_wr0 & !p_rd0);
                check("grant_has_req", p0 | p1, 1);
                check("grant_addr", s_address, e ? p_a1 : p_a0);
                check("grant_rd", s_read, e_rd);
                check("grant_wr", s_write, e_wr);
                if (e_wr) check("grant_wdata", {s_byteenable, s_writedata},
                                e ? {p_be1, p_d1} : {p_be0, p_d0});
                if (e) mdl_starve = 0;
                else if (p1 && mdl_starve < SMAX) mdl_starve++;
                mdl_last = e; own = e;
                act_q.push_back(s_address[AW-1]);
            end
            acc = (s_read || s_write) && !s_waitrequest;
            check("m0_waitreq", m0_waitrequest, !(acc && own == 0));
            check("m1_waitreq", m1_waitrequest, !(acc && own == 1));
        end
        prev_cmd = s_read | s_write;
        p_rd0 = m0_read; p_wr0 = m0_write; p_a0 = m0_address; p_d0 = m0_writedata; p_be0 = m0_byteenable;
        p_rd1 = m1_read; p_wr1 = m1_write; p_a1 = m1_address; p_d1 = m1_writedata; p_be1 = m1_byteenable;
        p_urg = m0_urgent;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_op(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
        int   n;
        logic wt;
        if (p == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            wt = (p == 0) ? m0_waitrequest : m1_waitrequest;
        end while (wt && n < WAIT_BOUND);
        if (wt) check((p == 0) ? "m0_timeout" : "m1_timeout", wt, 0);
        else if (rd) begin
            if (p == 0) exp_q0.push_back(ref_get(a));
            else        exp_q1.push_back(ref_get(a));
        end else if (wr) ref_mem[a] = merge(ref_get(a), d, be);
        @(posedge clk); #1;
        if (p == 0) begin m0_read = 0; m0_write = 0; end
        else        begin m1_read = 0; m1_write = 0; end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_read"},  s_read, 0);
        check({tag, "_s_write"}, s_write, 0);
        check({tag, "_s_addr"},  s_address, 0);
        check({tag, "_s_wdata"}, s_writedata, 0);
        check({tag, "_s_be"},    s_byteenable, 0);
        check({tag, "_rdv0"},    m0_readdatavalid, 0);
        check({tag, "_rdv1"},    m1_readdatavalid, 0);
        check({tag, "_rdata0"},  m0_readdata, 0);
        check({tag, "_rdata1"},  m1_readdata, 0);
        check({tag, "_wait0"},   m0_waitrequest, 1);
        check({tag, "_wait1"},   m1_waitrequest, 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  cnt, fall_at, zeros, first1, b0, b1;
        bit  sw_seen, done0, done1;

        #12;
        check_reset("rst_init");
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // port-1 write, slave stalls three cycles
        stall_cfg = 3;
        cnt = 0; fall_at = 0;
        fork
            m_op(1, 0, 1, 25'h0000123, 16'hBEEF, 2'b11);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (s_write) cnt++;
                if (s_write && !m1_waitrequest) fall_at = cnt;
            end
        join
        tick(1);
        stall_cfg = -1;
        check("wr_s_write_cycles", cnt, 4);
        check("wr_wait_fall_cycle", fall_at, 4);
        check("wr_sdram_data", sd_get(25'h0000123), 16'hBEEF);

        // simultaneous reads, port 0 wins first
        sd_mem[25'h0000040] = 16'hA5A5;  ref_mem[25'h0000040] = 16'hA5A5;
        sd_mem[25'h1000040] = 16'h5A5A;  ref_mem[25'h1000040] = 16'h5A5A;
        act_q.delete();
        b0 = rdv_cnt0; b1 = rdv_cnt1;
        fork
            m_op(0, 1, 0, 25'h0000040, 16'h0, 2'b11);
            m_op(1, 1, 0, 25'h1000040, 16'h0, 2'b11);
        join
        tick(10);
        check("both_grants", act_q.size(), 2);
        if (act_q.size() == 2) begin
            check("both_first_port", act_q[0], 0);
            check("both_second_port", act_q[1], 1);
        end
        check("both_rdv0_count", rdv_cnt0 - b0, 1);
        check("both_rdv1_count", rdv_cnt1 - b1, 1);
        check("both_rdata0", m0_readdata, 16'hA5A5);
        check("both_rdata1", m1_readdata, 16'h5A5A);

        // stray slave readdatavalid while idle
        stray_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        end
        tick(1);

        // reset while waiting for read data
        lat_cfg = 6;
        sd_mem[25'h1000077] = 16'h7777;  ref_mem[25'h1000077] = 16'h7777;
        m_op(1, 1, 0, 25'h1000077, 16'h0, 2'b11);
        reset_n = 1'b0;
        #1;
        check_reset("rst_async");
        tick(2);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset("rst_release");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_late_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        end
        tick(1);
        lat_cfg = -1;

        // read and write together is a read
        sd_mem[25'h0000055] = 16'h1234;  ref_mem[25'h0000055] = 16'h1234;
        sw_seen = 0;
        fork
            m_op(0, 1, 1, 25'h0000055, 16'hFFFF, 2'b11);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                sw_seen |= s_write;
            end
        join
        tick(6);
        check("rw_no_write", sw_seen, 0);
        check("rw_sdram_untouched", sd_get(25'h0000055), 16'h1234);
        check("rw_rdata0", m0_readdata, 16'h1234);

        // urgent port 0 saturates the starve counter
        act_q.delete();
        m0_urgent = 1'b1;
        fork
            for (int i = 0; i < 34; i++) m_op(0, 1, 0, 25'h0000100 + AW'(i), 16'h0, 2'b11);
            m_op(1, 1, 0, 25'h1000100, 16'h0, 2'b11);
        join
        m0_urgent = 1'b0;
        tick(8);
        zeros = 0; first1 = -1;
        foreach (act_q[i]) begin
            if (act_q[i] && first1 < 0) first1 = i;
            if (!act_q[i] && first1 < 0) zeros++;
        end
        check("starve_grants", act_q.size(), 35);
        check("starve_p0_before_p1", zeros, SMAX);
        check("starve_p1_index", first1, SMAX);
        if (act_q.size() > SMAX + 1) check("starve_p0_after", act_q[SMAX+1], 0);

        // randomized traffic
        done0 = 0; done1 = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    int k;
                    k = $urandom_range(0, 2);
                    m_op(0, k != 1, k != 0, {1'b0, 19'h0, 5'($urandom)}, 16'($urandom),
                         2'($urandom_range(1, 3)));
                    tick($urandom_range(0, 2));
                end
                done0 = 1;
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    int k;
                    k = $urandom_range(0, 2);
                    m_op(1, k != 1, k != 0, {1'b1, 19'h0, 5'($urandom)}, 16'($urandom),
                         2'($urandom_range(1, 3)));
                    tick($urandom_range(0, 3));
                end
                done1 = 1;
            end
            begin
                while (!(done0 && done1)) begin
                    tick(1);
                    m0_urgent = ($urandom_range(0, 3) == 0);
                end
                m0_urgent = 1'b0;
            end
        join
        tick(12);
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
